// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch control slice.
// Holds the BCD snapshot layout, the run-state encoding and parameter defaults.
package stopwatch_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 3;
  localparam int LAP_DEPTH_DEF       = 4;
  localparam int HOLD_CYCLES_DEF     = 200;

  typedef struct packed {
    logic [3:0] min;
    logic [3:0] tensec;
    logic [3:0] sec;
    logic [3:0] decisec;
    logic [3:0] centisec;
  } bcd_time_t;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } run_state_e;

  function automatic run_state_e toggle_run(input run_state_e state);
    return (state == RUNNING) ? STOPPED : RUNNING;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, debounce counter and press-pulse generator for one
// raw active-low push-button.
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic button_l,
  output logic press
);

  localparam logic [3:0] LAST_COUNT = 4'(DEBOUNCE_CYCLES - 1);

  logic       sync_q1;
  logic       sync_q2;
  logic       level_q;
  logic [3:0] count_q;
  logic       accept;

  // The pulse is decoded from the counter so the consumer acts on the same
  // edge that accepts the new level, giving 2 + DEBOUNCE_CYCLES of latency.
  assign accept = (sync_q2 != level_q) && (count_q == LAST_COUNT);
  assign press  = accept && !sync_q2;

  // NOTE: non-blocking assignments let every flop sample pre-edge values, so
  // sync_q2 really lags sync_q1 by one cycle instead of collapsing the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      level_q <= 1'b1;
      count_q <= '0;
    end else begin
      sync_q1 <= button_l;
      sync_q2 <= sync_q1;
      if (sync_q2 == level_q) begin
        count_q <= '0;
      end else if (accept) begin
        level_q <= sync_q2;
        count_q <= '0;
      end else begin
        count_q <= count_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/lap/recall control with lap ring buffer and display select.
// Optional live-display freeze after a lap: define STOPWATCH_LAP_HOLD_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LAP_DEPTH       = LAP_DEPTH_DEF
`ifdef STOPWATCH_LAP_HOLD_EN
  ,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
`endif
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START_STOP_L,
  input  logic       LAP_L,
  input  logic       RECALL_L,
  input  logic [3:0] MIN,
  input  logic [3:0] TENSEC,
  input  logic [3:0] SEC,
  input  logic [3:0] DECISEC,
  input  logic [3:0] CENTISEC,
  output logic       ENABLE,
  output logic       CLEAR,
  output logic [3:0] DISP_MIN,
  output logic [3:0] DISP_TENSEC,
  output logic [3:0] DISP_SEC,
  output logic [3:0] DISP_DECISEC,
  output logic [3:0] DISP_CENTISEC,
  output logic       RECALL_ACT,
  output logic [2:0] LAP_IDX,
  output logic [3:0] LAP_COUNT
);

  localparam int         PTR_W       = $clog2(LAP_DEPTH);
  localparam logic [3:0] DEPTH_COUNT = 4'(LAP_DEPTH);

  logic             ss_press;
  logic             lap_press;
  logic             recall_press;
  run_state_e       run_state;
  run_state_e       next_run;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [3:0]       lap_count;
  logic [2:0]       lap_idx;
  logic             recall_act;
  logic             clear_q;
  logic             store_lap;
  logic             clear_laps;
  logic             recall_step;
  bcd_time_t        live;
  bcd_time_t        live_view;
  bcd_time_t        shown;
  bcd_time_t        lap_mem [LAP_DEPTH];

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_stop (
    .clk(CLK), .reset(RESET), .button_l(START_STOP_L), .press(ss_press)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
    .clk(CLK), .reset(RESET), .button_l(LAP_L), .press(lap_press)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_recall (
    .clk(CLK), .reset(RESET), .button_l(RECALL_L), .press(recall_press)
  );

  assign live = bcd_time_t'({MIN, TENSEC, SEC, DECISEC, CENTISEC});

  // NOTE: every signal below is assigned on every path through the block, so
  // no latch can be inferred.
  always_comb begin
    next_run    = ss_press ? toggle_run(run_state) : run_state;
    // Lap is judged in the post-toggle state: stop+lap clears, start+lap stores.
    store_lap   = lap_press && (next_run == RUNNING);
    clear_laps  = lap_press && (next_run == STOPPED);
    recall_step = recall_press && !lap_press && !ss_press && (lap_count != 4'd0);
    rd_ptr      = wr_ptr - PTR_W'(1) - PTR_W'(lap_idx);
    shown       = recall_act ? lap_mem[rd_ptr] : live_view;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      run_state  <= STOPPED;
      wr_ptr     <= '0;
      lap_count  <= '0;
      lap_idx    <= '0;
      recall_act <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      run_state <= next_run;
      clear_q   <= clear_laps;
      if (ss_press) begin
        recall_act <= 1'b0;
        lap_idx    <= '0;
      end
      if (store_lap) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        lap_idx <= '0;
        if (lap_count != DEPTH_COUNT) lap_count <= lap_count + 4'd1;
      end else if (clear_laps) begin
        wr_ptr     <= '0;
        lap_count  <= '0;
        lap_idx    <= '0;
        recall_act <= 1'b0;
      end else if (recall_step) begin
        if (!recall_act) begin
          recall_act <= 1'b1;
          lap_idx    <= '0;
        end else if (({1'b0, lap_idx} + 4'd1) == lap_count) begin
          recall_act <= 1'b0;
          lap_idx    <= '0;
        end else begin
          lap_idx <= lap_idx + 3'd1;
        end
      end
    end
  end

  // NOTE: the lap storage has no reset; LAP_COUNT gates every read, so stale
  // contents are never displayed and the array can map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (store_lap && !RESET) lap_mem[wr_ptr] <= live;
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic [HOLD_W-1:0] hold_cnt;
  bcd_time_t         hold_snap;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hold_cnt  <= '0;
      hold_snap <= '0;
    end else if (store_lap) begin
      hold_cnt  <= HOLD_W'(HOLD_CYCLES);
      hold_snap <= live;
    end else if (ss_press || recall_press) begin
      hold_cnt <= '0;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HOLD_W'(1);
    end
  end

  assign live_view = (hold_cnt != '0) ? hold_snap : live;
`else
  assign live_view = live;
`endif

  assign ENABLE        = (run_state == RUNNING);
  assign CLEAR         = clear_q;
  assign RECALL_ACT    = recall_act;
  assign LAP_IDX       = lap_idx;
  assign LAP_COUNT     = lap_count;
  assign DISP_MIN      = shown.min;
  assign DISP_TENSEC   = shown.tensec;
  assign DISP_SEC      = shown.sec;
  assign DISP_DECISEC  = shown.decisec;
  assign DISP_CENTISEC = shown.centisec;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a queue-based behavioural model is
// compared every cycle, plus directed literal expectations.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int DB    = DEBOUNCE_CYCLES_DEF;
  localparam int DEPTH = LAP_DEPTH_DEF;

  logic        CLK   = 1'b0;
  logic        RESET = 1'b1;
  logic [2:0]  btn_l = 3'b111;   // [0] start_stop, [1] lap, [2] recall
  logic [19:0] live  = '0;
  logic        ENABLE, CLEAR, RECALL_ACT;
  logic [2:0]  LAP_IDX;
  logic [3:0]  LAP_COUNT;
  logic [3:0]  DISP_MIN, DISP_TENSEC, DISP_SEC, DISP_DECISEC, DISP_CENTISEC;
  logic [19:0] disp;

  int errors = 0;
  int checks = 0;

  stopwatch_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .START_STOP_L(btn_l[0]), .LAP_L(btn_l[1]), .RECALL_L(btn_l[2]),
    .MIN(live[19:16]), .TENSEC(live[15:12]), .SEC(live[11:8]),
    .DECISEC(live[7:4]), .CENTISEC(live[3:0]),
    .ENABLE(ENABLE), .CLEAR(CLEAR),
    .DISP_MIN(DISP_MIN), .DISP_TENSEC(DISP_TENSEC), .DISP_SEC(DISP_SEC),
    .DISP_DECISEC(DISP_DECISEC), .DISP_CENTISEC(DISP_CENTISEC),
    .RECALL_ACT(RECALL_ACT), .LAP_IDX(LAP_IDX), .LAP_COUNT(LAP_COUNT)
  );

  assign disp = {DISP_MIN, DISP_TENSEC, DISP_SEC, DISP_DECISEC, DISP_CENTISEC};

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raw-sample history per button, laps kept newest-first.
  bit          hist [3][$];
  bit          acc  [3];
  bit          ev   [3];
  bit          all_diff;
  bit          stored;
  bit          m_run, m_recall, m_clear, m_valid;
  int          m_idx;
  int          m_hold;
  logic [19:0] m_snap;
  logic [19:0] laps [$];

  initial begin
    m_valid = 1'b0;
    m_hold  = 0;
    forever begin
      @(posedge CLK);
      if (RESET) begin
        for (int b = 0; b < 3; b++) begin
          hist[b].delete();
          for (int k = 0; k < DB + 2; k++) hist[b].push_front(1'b1);
          acc[b] = 1'b1;
        end
        m_run = 0; m_recall = 0; m_clear = 0; m_idx = 0; m_hold = 0;
        laps.delete();
        m_valid = 1'b1;
      end else begin
        // A level is accepted once the last DB synchronized samples
        // (raw samples from 2..DB+1 edges ago) all differ from it.
        for (int b = 0; b < 3; b++) begin
          ev[b] = 1'b0;
          all_diff = 1'b1;
          for (int k = 1; k <= DB; k++) if (hist[b][k] == acc[b]) all_diff = 1'b0;
          if (all_diff) begin
            ev[b]  = acc[b];
            acc[b] = !acc[b];
          end
          hist[b].push_front(btn_l[b]);
          void'(hist[b].pop_back());
        end
        m_clear = 0;
        stored  = 0;
        if (ev[0]) begin
          m_run = !m_run; m_recall = 0; m_idx = 0;
        end
        if (ev[1]) begin
          if (m_run) begin
            laps.push_front(live);
            if (laps.size() > DEPTH) void'(laps.pop_back());
            m_idx  = 0;
            stored = 1;
          end else begin
            m_clear = 1; laps.delete(); m_recall = 0; m_idx = 0;
          end
        end else if (ev[2] && !ev[0] && laps.size() != 0) begin
          if (!m_recall) begin
            m_recall = 1; m_idx = 0;
          end else if (m_idx + 1 == laps.size()) begin
            m_recall = 0; m_idx = 0;
          end else begin
            m_idx++;
          end
        end
`ifdef STOPWATCH_LAP_HOLD_EN
        if (stored) begin
          m_hold = HOLD_CYCLES_DEF; m_snap = live;
        end else if (ev[0] || ev[2]) begin
          m_hold = 0;
        end else if (m_hold > 0) begin
          m_hold--;
        end
`endif
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (m_valid) begin
        logic [19:0] exp_disp;
        if (m_recall)        exp_disp = laps[m_idx];
        else if (m_hold > 0) exp_disp = m_snap;
        else                 exp_disp = live;
        check("model_enable", ENABLE, m_run);
        check("model_clear", CLEAR, m_clear);
        check("model_recall_act", RECALL_ACT, m_recall);
        check("model_lap_idx", LAP_IDX, m_idx);
        check("model_lap_count", LAP_COUNT, laps.size());
        check("model_disp", disp, exp_disp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press(input int b);
    btn_l[b] = 1'b0;
    tick(8);
    btn_l[b] = 1'b1;
    tick(8);
  endtask

  initial begin
    tick(3);
    RESET = 1'b0;
    tick(1);
    check("rst_enable", ENABLE, 0);
    check("rst_clear", CLEAR, 0);
    check("rst_recall", RECALL_ACT, 0);
    check("rst_idx", LAP_IDX, 0);
    check("rst_count", LAP_COUNT, 0);

    // Two-cycle glitch must be rejected.
    btn_l[0] = 1'b0;
    tick(2);
    btn_l[0] = 1'b1;
    tick(10);
    check("glitch_enable", ENABLE, 0);

    // Start: ENABLE rises exactly 2+DB edges after the raw fall.
    btn_l[0] = 1'b0;
    for (int i = 1; i < 2 + DB; i++) begin
      tick(1);
      check("start_latency_low", ENABLE, 0);
    end
    tick(1);
    check("start_latency_high", ENABLE, 1);
    tick(5);
    check("start_single_pulse", ENABLE, 1);
    btn_l[0] = 1'b1;
    tick(8);
    check("release_no_event", ENABLE, 1);

    // Three laps, then recall walks newest to oldest and exits.
    live = 20'h00012; press(1);
    live = 20'h00150; press(1);
    live = 20'h00207; press(1);
    live = 20'h95999;
    check("three_laps_count", LAP_COUNT, 3);
    press(2);
    check("recall1_act", RECALL_ACT, 1);
    check("recall1_idx", LAP_IDX, 0);
    check("recall1_disp", disp, 20'h00207);
    press(2);
    check("recall2_idx", LAP_IDX, 1);
    check("recall2_disp", disp, 20'h00150);
    press(2);
    check("recall3_disp", disp, 20'h00012);
    press(2);
    check("recall4_act", RECALL_ACT, 0);
    check("recall4_live", disp, 20'h95999);
    check("recall_keeps_running", ENABLE, 1);

    // Stop, then lap clears: CLEAR is a single-cycle pulse.
    press(0);
    check("stop_enable", ENABLE, 0);
    btn_l[1] = 1'b0;
    tick(1 + DB);
    check("clear_before", CLEAR, 0);
    tick(1);
    check("clear_pulse", CLEAR, 1);
    check("clear_count", LAP_COUNT, 0);
    tick(1);
    check("clear_after", CLEAR, 0);
    btn_l[1] = 1'b1;
    tick(8);
    press(2);
    check("recall_empty_ignored", RECALL_ACT, 0);

    // Five laps into a four-deep buffer: oldest overwritten.
    press(0);
    for (int k = 1; k <= 5; k++) begin
      live = 20'(k << 8);
      press(1);
    end
    check("wrap_count", LAP_COUNT, 4);
    for (int k = 5; k >= 2; k--) begin
      press(2);
      check("wrap_recall_disp", disp, 20'(k << 8));
      check("wrap_recall_idx", LAP_IDX, 5 - k);
    end
    press(2);
    check("wrap_recall_exit", RECALL_ACT, 0);

    // Lap during recall stores and jumps back to the newest entry.
    press(2);
    press(2);
    check("pre_lap_idx", LAP_IDX, 1);
    live = 20'h00600;
    press(1);
    check("lap_in_recall_idx", LAP_IDX, 0);
    check("lap_in_recall_disp", disp, 20'h00600);
    check("lap_in_recall_count", LAP_COUNT, 4);

    // Start_stop during recall stops and exits recall.
    live = 20'h12345;
    press(0);
    check("stop_exits_recall", RECALL_ACT, 0);
    check("stop_exits_enable", ENABLE, 0);
    press(0);

    // Stop+lap together while running: clears.
    btn_l = 3'b100;
    tick(2 + DB);
    check("sim_stop_enable", ENABLE, 0);
    check("sim_stop_clear", CLEAR, 1);
    check("sim_stop_count", LAP_COUNT, 0);
    btn_l = 3'b111;
    tick(8);

    // Start+lap together while stopped: stores.
    live = 20'h00042;
    btn_l = 3'b100;
    tick(8);
    btn_l = 3'b111;
    tick(8);
    check("sim_start_enable", ENABLE, 1);
    check("sim_start_count", LAP_COUNT, 1);

    // Reset mid-operation.
    press(2);
    check("pre_reset_recall", RECALL_ACT, 1);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    check("midrst_enable", ENABLE, 0);
    check("midrst_recall", RECALL_ACT, 0);
    check("midrst_count", LAP_COUNT, 0);
    check("midrst_clear", CLEAR, 0);
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
